// File: rtl/imem_pkg.sv
// Package: imem_pkg
// Shared definitions for the instruction-memory access arbiter:
//   - default RAM geometry (word-address width, instruction width)
//   - response owner encoding
//   - byte-address legality check (word alignment + inside RAM range)
package imem_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LOAD  = 2'd2
   } owner_t;

   // Returns 1 when a byte address is misaligned or lies beyond a RAM of
   // 2**aw words, i.e. any bit above addr[aw+1] is set.
   function automatic logic addr_bad(input logic [31:0] addr, input int unsigned aw);
      logic [31:0] hi_mask;
      hi_mask = ~((32'd1 << (aw + 2)) - 32'd1);
      return (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'd0);
   endfunction

endpackage

// File: rtl/imem_rr_arb2.sv
// Module: imem_rr_arb2
// Two-way round-robin arbiter with a mask on requester A.
// Ports:
//   clk, rst      clock / asynchronous active-low reset
//   req_a, req_b  requests (A = fetch, B = loader)
//   mask_a        when high, requester A is never granted
//   gnt_a, gnt_b  one-hot (or zero) grants, combinational
// The last-grant pointer resets to B so that A wins the first contention,
// and it only moves on a cycle that actually grants someone.
module imem_rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic mask_a,
   output logic gnt_a,
   output logic gnt_b
);

   logic last_b_reg;
   logic last_b_next;
   logic req_a_eff;

   assign req_a_eff = req_a & ~mask_a;

   always_comb begin
      gnt_a       = 1'b0;
      gnt_b       = 1'b0;
      last_b_next = last_b_reg;
      if (req_a_eff && req_b) begin
         // contention: whoever was not served last time goes now
         gnt_a = last_b_reg;
         gnt_b = ~last_b_reg;
      end else begin
         gnt_a = req_a_eff;
         gnt_b = req_b;
      end
      if (gnt_a || gnt_b) begin
         last_b_next = gnt_b;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_b_reg <= 1'b1;
      end else begin
         last_b_reg <= last_b_next;
      end
   end

endmodule

// File: rtl/imem_access_arbiter.sv
// Module: imem_access_arbiter
// Shares one single-port synchronous instruction RAM between the core fetch
// port (read-only) and the loader/debug port (read/write).
// Ports:
//   clk, rst                       clock / asynchronous active-low reset
//   f_req, f_addr                  fetch request, byte address
//   f_gnt, f_rvalid, f_rdata, f_err fetch grant and 1-cycle-later response
//   ld_req, ld_we, ld_addr, ld_wdata, ld_lock   loader request side
//   ld_gnt, ld_rvalid, ld_rdata, ld_err          loader grant / response
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata  RAM interface
//   core_stall                     fetch blocked by lock or lost arbitration
// Grants are combinational; the response owner and error flag are
// registered so the response lines up with the RAM's 1-cycle read latency.
module imem_access_arbiter
   import imem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [31:0]       f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   output logic              f_err,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [31:0]       ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   input  logic              ld_lock,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              ld_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              core_stall
);

   logic   f_bad, ld_bad;
   logic   gnt_f, gnt_l;
   logic   good_f, good_l;
   owner_t own_reg, own_next;
   logic   err_reg, err_next;
   logic   wr_reg, wr_next;

   assign f_bad  = addr_bad(f_addr, ADDR_W);
   assign ld_bad = addr_bad(ld_addr, ADDR_W);

   // Requests are qualified with rst so every output stays low during reset.
   imem_rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req_a  (f_req & rst),
      .req_b  (ld_req & rst),
      .mask_a (ld_lock),
      .gnt_a  (gnt_f),
      .gnt_b  (gnt_l)
   );

   assign f_gnt      = gnt_f;
   assign ld_gnt     = gnt_l;
   assign core_stall = rst & (ld_lock | (f_req & ~gnt_f));

   always_comb begin
      good_f    = gnt_f & ~f_bad;
      good_l    = gnt_l & ~ld_bad;
      mem_en    = good_f | good_l;
      mem_we    = good_l & ld_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (good_l) begin
         mem_addr  = ld_addr[ADDR_W+1:2];
         mem_wdata = ld_wdata;
      end else if (good_f) begin
         mem_addr  = f_addr[ADDR_W+1:2];
      end

      // An errored grant still owns next cycle's response slot.
      own_next = OWN_NONE;
      err_next = 1'b0;
      wr_next  = 1'b0;
      if (gnt_f) begin
         own_next = OWN_FETCH;
         err_next = f_bad;
      end else if (gnt_l) begin
         own_next = OWN_LOAD;
         err_next = ld_bad;
         wr_next  = ld_we;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         own_reg <= OWN_NONE;
         err_reg <= 1'b0;
         wr_reg  <= 1'b0;
      end else begin
         own_reg <= own_next;
         err_reg <= err_next;
         wr_reg  <= wr_next;
      end
   end

   assign f_rvalid  = (own_reg == OWN_FETCH);
   assign ld_rvalid = (own_reg == OWN_LOAD);
   assign f_err     = f_rvalid & err_reg;
   assign ld_err    = ld_rvalid & err_reg;
   assign f_rdata   = (f_rvalid && !err_reg) ? mem_rdata : '0;
   assign ld_rdata  = (ld_rvalid && !err_reg && !wr_reg) ? mem_rdata : '0;

endmodule
